// File: rtl/alu_mul_pipe.sv
// alu_mul_pipe: fully pipelined unsigned multiplier with stall/flush, hazard lookup and occupancy count.
// Optional feature: define ALU_MUL_OVERFLOW_XCPT_EN to build and pipeline the product-overflow flag.
module alu_mul_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 5,
    parameter int ADDR_WIDTH  = 5,
    parameter int PC_WIDTH    = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               stall_mul,
    input  logic                               flush_mul,
    input  logic                               req_mul_valid,
    input  logic [DATA_WIDTH-1:0]              req_mul_ra_data,
    input  logic [DATA_WIDTH-1:0]              req_mul_rb_data,
    input  logic [ADDR_WIDTH-1:0]              req_mul_rd_addr,
    input  logic [PC_WIDTH-1:0]                req_mul_pc,
    output logic                               rsp_mul_valid,
    output logic [DATA_WIDTH-1:0]              rsp_mul_data,
    output logic [ADDR_WIDTH-1:0]              rsp_mul_rd_addr,
    output logic [PC_WIDTH-1:0]                rsp_mul_pc,
    output logic                               rsp_mul_xcpt_overflow,
    input  logic [ADDR_WIDTH-1:0]              hz_query_addr,
    output logic                               hz_match,
    output logic [$clog2(MUL_LATENCY+1)-1:0]   mul_occupancy,
    output logic                               mul_busy
);

    localparam int OCC_WIDTH = $clog2(MUL_LATENCY + 1);

    if (MUL_LATENCY < 1) begin : g_bad_latency
        $error("alu_mul_pipe: MUL_LATENCY must be at least 1");
    end

    // Stage index 0 is the first register, MUL_LATENCY-1 is the output register.
    logic [MUL_LATENCY-1:0] vld_r;
    logic [MUL_LATENCY-1:0] vld_nxt_s;
    logic [DATA_WIDTH-1:0]  data_r [MUL_LATENCY];
    logic [ADDR_WIDTH-1:0]  rd_r   [MUL_LATENCY];
    logic [PC_WIDTH-1:0]    pc_r   [MUL_LATENCY];
    logic [OCC_WIDTH-1:0]   occ_r;
    logic [OCC_WIDTH-1:0]   occ_nxt_s;
    logic [DATA_WIDTH-1:0]  prod_lo_s;
    logic                   hz_match_s;

`ifdef ALU_MUL_OVERFLOW_XCPT_EN
    logic [2*DATA_WIDTH-1:0] prod_full_s;
    logic                    prod_ovf_s;
    logic                    ovf_r [MUL_LATENCY];

    assign prod_full_s = {{DATA_WIDTH{1'b0}}, req_mul_ra_data} * {{DATA_WIDTH{1'b0}}, req_mul_rb_data};
    assign prod_lo_s   = prod_full_s[DATA_WIDTH-1:0];
    assign prod_ovf_s  = |prod_full_s[2*DATA_WIDTH-1:DATA_WIDTH];

    // overflow flag travels with its operation; frozen under stall like the data fields
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < MUL_LATENCY; k++) begin
                ovf_r[k] <= 1'b0;
            end
        end else if (!stall_mul) begin
            if (req_mul_valid) begin
                ovf_r[0] <= prod_ovf_s;
            end
            for (int k = 1; k < MUL_LATENCY; k++) begin
                ovf_r[k] <= ovf_r[k-1];
            end
        end
    end

    assign rsp_mul_xcpt_overflow = ovf_r[MUL_LATENCY-1];
`else
    // Truncating multiply: only the low half is ever needed here.
    assign prod_lo_s             = req_mul_ra_data * req_mul_rb_data;
    assign rsp_mul_xcpt_overflow = 1'b0;
`endif

    // next valid vector: flush kills everything, stall holds, otherwise shift in the request
    always_comb begin
        vld_nxt_s = vld_r;
        if (flush_mul) begin
            vld_nxt_s = '0;
        end else if (stall_mul) begin
            vld_nxt_s = vld_r;
        end else begin
            vld_nxt_s[0] = req_mul_valid;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                vld_nxt_s[k] = vld_r[k-1];
            end
        end
    end

    // occupancy is the population count of next-cycle valid bits
    always_comb begin
        occ_nxt_s = '0;
        for (int k = 0; k < MUL_LATENCY; k++) begin
            occ_nxt_s = occ_nxt_s + OCC_WIDTH'(vld_nxt_s[k]);
        end
    end

    // valid and occupancy state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_r <= '0;
            occ_r <= '0;
        end else begin
            vld_r <= vld_nxt_s;
            occ_r <= occ_nxt_s;
        end
    end

    // payload pipeline: stage 0 loads only on a real request, the rest shift when not stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < MUL_LATENCY; k++) begin
                data_r[k] <= '0;
                rd_r[k]   <= '0;
                pc_r[k]   <= '0;
            end
        end else if (!stall_mul) begin
            if (req_mul_valid) begin
                data_r[0] <= prod_lo_s;
                rd_r[0]   <= req_mul_rd_addr;
                pc_r[0]   <= req_mul_pc;
            end
            for (int k = 1; k < MUL_LATENCY; k++) begin
                data_r[k] <= data_r[k-1];
                rd_r[k]   <= rd_r[k-1];
                pc_r[k]   <= pc_r[k-1];
            end
        end
    end

    // hazard lookup across every stage including the output register; register 0 never conflicts
    always_comb begin
        hz_match_s = 1'b0;
        if (hz_query_addr != '0) begin
            for (int k = 0; k < MUL_LATENCY; k++) begin
                hz_match_s = hz_match_s | (vld_r[k] & (rd_r[k] == hz_query_addr));
            end
        end else begin
            hz_match_s = 1'b0;
        end
    end

    assign hz_match        = hz_match_s;
    assign rsp_mul_valid   = vld_r[MUL_LATENCY-1];
    assign rsp_mul_data    = data_r[MUL_LATENCY-1];
    assign rsp_mul_rd_addr = rd_r[MUL_LATENCY-1];
    assign rsp_mul_pc      = pc_r[MUL_LATENCY-1];
    assign mul_occupancy   = occ_r;
    assign mul_busy        = (occ_r != '0);

endmodule

// File: tb/tb_alu_mul_pipe.sv
// Self-checking bench for alu_mul_pipe: directed scenarios plus randomized traffic against a queue model.
module tb_alu_mul_pipe;

    localparam int DW = 32;
    localparam int L  = 5;
    localparam int AW = 5;
    localparam int PW = 32;
    localparam int OW = $clog2(L + 1);
`ifdef ALU_MUL_OVERFLOW_XCPT_EN
    localparam logic EXP_OVF_BIG = 1'b1;
`else
    localparam logic EXP_OVF_BIG = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          stall_mul;
    logic          flush_mul;
    logic          req_mul_valid;
    logic [DW-1:0] req_mul_ra_data;
    logic [DW-1:0] req_mul_rb_data;
    logic [AW-1:0] req_mul_rd_addr;
    logic [PW-1:0] req_mul_pc;
    logic          rsp_mul_valid;
    logic [DW-1:0] rsp_mul_data;
    logic [AW-1:0] rsp_mul_rd_addr;
    logic [PW-1:0] rsp_mul_pc;
    logic          rsp_mul_xcpt_overflow;
    logic [AW-1:0] hz_query_addr;
    logic          hz_match;
    logic [OW-1:0] mul_occupancy;
    logic          mul_busy;

    always #5 clock = ~clock;

    alu_mul_pipe #(
        .DATA_WIDTH (DW),
        .MUL_LATENCY(L),
        .ADDR_WIDTH (AW),
        .PC_WIDTH   (PW)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .stall_mul            (stall_mul),
        .flush_mul            (flush_mul),
        .req_mul_valid        (req_mul_valid),
        .req_mul_ra_data      (req_mul_ra_data),
        .req_mul_rb_data      (req_mul_rb_data),
        .req_mul_rd_addr      (req_mul_rd_addr),
        .req_mul_pc           (req_mul_pc),
        .rsp_mul_valid        (rsp_mul_valid),
        .rsp_mul_data         (rsp_mul_data),
        .rsp_mul_rd_addr      (rsp_mul_rd_addr),
        .rsp_mul_pc           (rsp_mul_pc),
        .rsp_mul_xcpt_overflow(rsp_mul_xcpt_overflow),
        .hz_query_addr        (hz_query_addr),
        .hz_match             (hz_match),
        .mul_occupancy        (mul_occupancy),
        .mul_busy             (mul_busy)
    );

    // Model: in-flight operations in issue order, each aged by non-stalled edges since acceptance.
    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic [PW-1:0] pc;
        int            age;
    } op_t;

    op_t           q[$];
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    logic [AW-1:0] exp_rd    = '0;
    logic [PW-1:0] exp_pc    = '0;
    logic          exp_ovf   = 1'b0;
    bit            just_reset = 1'b0;
    int            n_total = 0;
    int            n_bad   = 0;
    int            peak_occ;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        op_t           nop;
        logic [63:0]   p;
        if (reset || flush_mul) begin
            q.delete();
            exp_valid = 1'b0;
        end else if (!stall_mul) begin
            foreach (q[i]) q[i].age++;
            while (q.size() > 0 && q[0].age > L) void'(q.pop_front());
            if (req_mul_valid) begin
                nop.a   = req_mul_ra_data;
                nop.b   = req_mul_rb_data;
                nop.rd  = req_mul_rd_addr;
                nop.pc  = req_mul_pc;
                nop.age = 1;
                q.push_back(nop);
            end
            exp_valid = (q.size() > 0 && q[0].age == L);
            if (exp_valid) begin
                p        = 64'(q[0].a) * 64'(q[0].b);
                exp_data = p[31:0];
                exp_rd   = q[0].rd;
                exp_pc   = q[0].pc;
`ifdef ALU_MUL_OVERFLOW_XCPT_EN
                exp_ovf  = (p[63:32] != 32'd0);
`else
                exp_ovf  = 1'b0;
`endif
            end
        end
        just_reset = reset;
    endtask

    task automatic check_outputs();
        logic exp_hz;
        exp_hz = 1'b0;
        if (hz_query_addr != '0) begin
            foreach (q[i]) if (q[i].rd == hz_query_addr) exp_hz = 1'b1;
        end
        check_eq("valid", rsp_mul_valid, exp_valid);
        check_eq("occupancy", mul_occupancy, q.size());
        check_eq("busy", mul_busy, q.size() != 0);
        check_eq("hz_match", hz_match, exp_hz);
        if (exp_valid) begin
            check_eq("data", rsp_mul_data, exp_data);
            check_eq("rd_addr", rsp_mul_rd_addr, exp_rd);
            check_eq("pc", rsp_mul_pc, exp_pc);
            check_eq("overflow", rsp_mul_xcpt_overflow, exp_ovf);
        end
        if (just_reset) begin
            check_eq("rst_data", rsp_mul_data, 64'd0);
            check_eq("rst_rd", rsp_mul_rd_addr, 64'd0);
            check_eq("rst_pc", rsp_mul_pc, 64'd0);
            check_eq("rst_ovf", rsp_mul_xcpt_overflow, 64'd0);
        end
        if (int'(mul_occupancy) > peak_occ) peak_occ = int'(mul_occupancy);
    endtask

    task automatic cycle(input bit rs, input bit st, input bit fl, input bit v,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] rd, input logic [PW-1:0] pc,
                         input logic [AW-1:0] qa);
        reset           = rs;
        stall_mul       = st;
        flush_mul       = fl;
        req_mul_valid   = v;
        req_mul_ra_data = a;
        req_mul_rb_data = b;
        req_mul_rd_addr = rd;
        req_mul_pc      = pc;
        hz_query_addr   = qa;
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic [AW-1:0] qa);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, qa);
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 5'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 5'd0);

        // single op 7*6 -> 42 after five edges
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd7, 32'd6, 5'd3, 32'h100, 5'd0);
        idle(4, 5'd0);
        check_eq("single_valid", rsp_mul_valid, 64'd1);
        check_eq("single_data", rsp_mul_data, 64'd42);
        check_eq("single_pc", rsp_mul_pc, 64'h100);
        idle(1, 5'd0);
        check_eq("single_idle", mul_busy, 64'd0);

        // overflow boundary
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h10000, 32'h10000, 5'd1, 32'h200, 5'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF, 32'hFFFF, 5'd2, 32'h204, 5'd0);
        idle(3, 5'd0);
        check_eq("big_data", rsp_mul_data, 64'd0);
        check_eq("big_ovf", rsp_mul_xcpt_overflow, EXP_OVF_BIG);
        idle(1, 5'd0);
        check_eq("ffff_data", rsp_mul_data, 64'hFFFE0001);
        check_eq("ffff_ovf", rsp_mul_xcpt_overflow, 64'd0);
        idle(2, 5'd0);

        // ten back-to-back ops
        peak_occ = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, DW'(i), 32'd2, AW'(i + 1), PW'(32'h300 + 4 * i), 5'd0);
        idle(6, 5'd0);
        check_eq("b2b_peak", peak_occ, 64'd5);

        // three ops then four stall cycles: first result two edges after the stall
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, DW'(i + 3), 32'd5, AW'(i + 7), PW'(32'h400 + 4 * i), 5'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'd99, 32'd99, 5'd30, 32'hDEAD, 5'd0);
        idle(1, 5'd0);
        check_eq("stall_early", rsp_mul_valid, 64'd0);
        idle(1, 5'd0);
        check_eq("stall_first", rsp_mul_data, 64'd15);
        idle(3, 5'd0);

        // flush with a concurrent request
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 32'd2, 5'd4, 32'h500, 5'd4);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 32'd3, 5'd5, 32'h504, 5'd4);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 32'd4, 5'd6, 32'h508, 5'd4);
        check_eq("flush_hz4", hz_match, 64'd0);
        check_eq("flush_occ", mul_occupancy, 64'd0);
        idle(6, 5'd4);

        // hazard lookup in stage 3, register 0 never matches, reset under stall
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 5'd9, 32'h600, 5'd9);
        idle(2, 5'd9);
        check_eq("hz9_stage3", hz_match, 64'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 5'd0, 32'h604, 5'd0);
        check_eq("hz0", hz_match, 64'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'd5, 32'd5, 5'd9, 32'h608, 5'd9);
        check_eq("rst_stall_valid", rsp_mul_valid, 64'd0);
        check_eq("rst_stall_occ", mul_occupancy, 64'd0);
        idle(6, 5'd9);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ra = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 65535)) : DW'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 65535)) : DW'($urandom);
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 70, ra, rb, AW'($urandom), PW'($urandom), AW'($urandom));
        end
        idle(8, 5'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mul_pipe.md
ALU_MUL_PIPE -- requirements
Module: alu_mul_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter MUL_LATENCY, default 5, number of pipeline stages; values below 1 SHALL be an elaboration error.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, destination register address width.
REQ-004 SHALL have parameter PC_WIDTH, default 32, PC tag width.
REQ-005 SHALL have ports (clock and reset first):
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- stall_mul  in  1  freeze every stage and the outputs
- flush_mul  in  1  kill all in-flight operations
- req_mul_valid  in  1  new multiply request
- req_mul_ra_data  in  DATA_WIDTH  operand A, unsigned
- req_mul_rb_data  in  DATA_WIDTH  operand B, unsigned
- req_mul_rd_addr  in  ADDR_WIDTH  destination register
- req_mul_pc  in  PC_WIDTH  instruction PC
- rsp_mul_valid  out  1  result valid
- rsp_mul_data  out  DATA_WIDTH  low DATA_WIDTH bits of product
- rsp_mul_rd_addr  out  ADDR_WIDTH  destination register of result
- rsp_mul_pc  out  PC_WIDTH  PC of result
- rsp_mul_xcpt_overflow  out  1  product exceeded DATA_WIDTH
- hz_query_addr  in  ADDR_WIDTH  register address checked for in-flight hazard
- hz_match  out  1  valid in-flight op writes hz_query_addr
- mul_occupancy  out  clog2(MUL_LATENCY+1)  count of valid stages
- mul_busy  out  1  mul_occupancy != 0

Function
REQ-006 SHALL be fully pipelined: one request accepted per non-stalled cycle, no back-pressure beyond stall_mul.
REQ-007 SHALL present a request accepted at edge N on rsp_* after exactly MUL_LATENCY non-stalled edges; stage MUL_LATENCY is the output register.
REQ-008 SHALL compute the full 2*DATA_WIDTH unsigned product; rsp_mul_data = low half; overflow = (high half != 0).
REQ-009 SHALL carry rd_addr, pc and valid with each operation; results leave in issue order.
REQ-010 SHALL, while stall_mul=1, hold all stage contents and all rsp_* outputs (including rsp_mul_valid) unchanged and ignore req_mul_valid; consumer samples rsp_* only when stall_mul=0.
REQ-011 SHALL, when flush_mul=1, clear every stage valid bit at that edge, discard a same-cycle request, and override stall_mul; data fields need not clear.
REQ-012 SHALL drive hz_match combinationally = 1 when any stage including the output stage is valid with rd_addr == hz_query_addr and hz_query_addr != 0.
REQ-013 SHALL update mul_occupancy each edge as valid stages +entering -leaving; range 0..MUL_LATENCY; full pipe with back-to-back requests holds at MUL_LATENCY.
REQ-014 SHALL, with MUL_LATENCY=1, behave as a single registered multiplier with identical handshake rules.

Reset
REQ-015 SHALL, on reset=1 at an edge, clear all valid bits, rsp_mul_data, rsp_mul_rd_addr, rsp_mul_pc, rsp_mul_xcpt_overflow and mul_occupancy to 0, regardless of stall_mul/flush_mul.
REQ-016 SHALL treat reset mid-operation as a flush: no in-flight result ever emerges afterwards.

Configuration
REQ-017 SHALL, with ALU_MUL_OVERFLOW_XCPT_EN defined, compute overflow per REQ-008 and pipeline it alongside the result.
REQ-018 SHALL, without ALU_MUL_OVERFLOW_XCPT_EN, tie rsp_mul_xcpt_overflow to 0 and not build the high-half product compare; all other behaviour unchanged.

Verification (DATA_WIDTH=32, MUL_LATENCY=5, overflow macro defined)
REQ-019 Single op 7*6, rd=3, pc=0x100 at cycle 0 -> rsp_mul_valid=1 cycle 5, data=42, rd=3, pc=0x100, overflow=0; mul_busy 1 for cycles 1..5.
REQ-020 0x10000*0x10000 -> data=0x0, overflow=1; 0xFFFF*0xFFFF -> data=0xFFFE0001, overflow=0.
REQ-021 Ten back-to-back ops a=i, b=2 -> results 0,2,..,18 in order on consecutive cycles 5..14; mul_occupancy peaks at 5.
REQ-022 Three ops issued, stall_mul=1 for 4 cycles after cycle 2 -> rsp_* frozen during stall, first result at cycle 9, order intact.
REQ-023 Ops rd=4,5 in flight, flush_mul=1 with concurrent request -> no rsp_mul_valid afterwards, occupancy 0 next cycle, hz_match(4)=0.
REQ-024 Op rd=9 in stage 3, query 9 -> hz_match=1; query 0 with rd=0 in flight -> hz_match=0; reset asserted with stall_mul=1 -> all outputs 0 next cycle.
